// File: rtl/vehicle_detector.sv
// vehicle_detector: loop-sensor front end for the intersection light controller.
// Synchronizes and debounces the raw loop input, latches a vehicle request until
// the controller shows GREEN, counts qualified arrivals and flags a stuck sensor.
// A stuck sensor fails safe by holding CarDetected asserted.
module vehicle_detector #(
   parameter int DEBOUNCE    = 4,     // consecutive synchronized cycles to accept a change (2..255)
   parameter int STUCK_LIMIT = 1024,  // occupancy cycles before the sensor is declared stuck
   parameter int CNT_W       = 8      // width of CarCount
) (
   input  logic             clk,
   input  logic             reset,        // asynchronous, active-low
   input  logic             LoopRaw,      // raw loop sensor, asynchronous to clk
   input  logic [1:0]       LightState,   // 0 RED, 1 GREEN, 2 YELLOW, 3 invalid
   input  logic             ClearFault,   // one-cycle request to clear Fault
   output logic             CarDetected,
   output logic [CNT_W-1:0] CarCount,
   output logic             Fault
);

   localparam int DEB_W   = $clog2(DEBOUNCE) + 1;
   localparam int DWELL_W = $clog2(STUCK_LIMIT + 1);

   localparam logic [DEB_W-1:0]   DEB_LAST  = DEB_W'(DEBOUNCE - 1);
   localparam logic [DWELL_W-1:0] DWELL_MAX = DWELL_W'(STUCK_LIMIT);
   localparam logic [1:0]         GREEN     = 2'd1;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      ARRIVE  = 2'd1,
      PRESENT = 2'd2,
      DEPART  = 2'd3
   } state_t;

   logic               sync1;
   logic               loop_s;
   state_t             state;
   state_t             state_nx;
   logic [DEB_W-1:0]   deb;
   logic [DEB_W-1:0]   deb_nx;
   logic [DWELL_W-1:0] dwell;
   logic [DWELL_W-1:0] dwell_nx;
   logic               req;
   logic               req_nx;
   logic               fault_nx;
   logic               arrival;
   logic               occupied;
   logic               occupied_nx;

   // Two-flop synchronizer: the only logic that samples LoopRaw.
   // NOTE: flops use non-blocking assignments so every register sees pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync1  <= 1'b0;
         loop_s <= 1'b0;
      end else begin
         sync1  <= LoopRaw;
         loop_s <= sync1;
      end
   end

   // Debounce state machine: next state and debounce count.
   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_nx = state;
      deb_nx   = deb;
      case (state)
         IDLE: begin
            if (loop_s) begin
               state_nx = ARRIVE;
               deb_nx   = DEB_W'(1);
            end
         end
         ARRIVE: begin
            if (!loop_s) begin
               // glitch rejected, not counted
               state_nx = IDLE;
               deb_nx   = '0;
            end else if (deb == DEB_LAST) begin
               state_nx = PRESENT;
               deb_nx   = '0;
            end else begin
               deb_nx = deb + 1'b1;
            end
         end
         PRESENT: begin
            if (!loop_s) begin
               state_nx = DEPART;
               deb_nx   = DEB_W'(1);
            end
         end
         DEPART: begin
            if (loop_s) begin
               // same vehicle bouncing: back to PRESENT without a recount
               state_nx = PRESENT;
               deb_nx   = '0;
            end else if (deb == DEB_LAST) begin
               state_nx = IDLE;
               deb_nx   = '0;
            end else begin
               deb_nx = deb + 1'b1;
            end
         end
         default: begin
            state_nx = IDLE;
            deb_nx   = '0;
         end
      endcase
   end

   // Arrival detection, request latch, dwell counter and fault flag next values.
   always_comb begin
      arrival     = (state == ARRIVE) && (state_nx == PRESENT);
      occupied    = (state == PRESENT) || (state == DEPART);
      occupied_nx = (state_nx == PRESENT) || (state_nx == DEPART);

      // set wins over a GREEN clear; invalid light (3) never clears
      if (arrival) begin
         req_nx = 1'b1;
      end else if (LightState == GREEN) begin
         req_nx = 1'b0;
      end else begin
         req_nx = req;
      end

      if (ClearFault || (state_nx == IDLE)) begin
         dwell_nx = '0;
      end else if (occupied && (dwell != DWELL_MAX)) begin
         dwell_nx = dwell + 1'b1;
      end else begin
         dwell_nx = dwell;
      end

      // a clear coinciding with the limit wins; dwell restarts from zero
      if (ClearFault) begin
         fault_nx = 1'b0;
      end else begin
         fault_nx = Fault || (dwell_nx == DWELL_MAX);
      end
   end

   // State register and registered outputs; CarDetected follows next-state values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         deb         <= '0;
         dwell       <= '0;
         req         <= 1'b0;
         Fault       <= 1'b0;
         CarDetected <= 1'b0;
         CarCount    <= '0;
      end else begin
         state       <= state_nx;
         deb         <= deb_nx;
         dwell       <= dwell_nx;
         req         <= req_nx;
         Fault       <= fault_nx;
         CarDetected <= fault_nx || req_nx || occupied_nx;
         if (arrival && (CarCount != '1)) begin
            CarCount <= CarCount + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vehicle_detector.sv
// tb_vehicle_detector: directed-vector bench for vehicle_detector with
// DEBOUNCE=4, STUCK_LIMIT=16, CNT_W=8. Inputs change 1 ns after a rising edge
// and outputs are sampled at the same point, away from the active edge.
module tb_vehicle_detector;

   logic       clk;
   logic       reset;
   logic       LoopRaw;
   logic [1:0] LightState;
   logic       ClearFault;
   logic       CarDetected;
   logic [7:0] CarCount;
   logic       Fault;

   int tests;
   int failures;

   vehicle_detector #(
      .DEBOUNCE   (4),
      .STUCK_LIMIT(16),
      .CNT_W      (8)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .LoopRaw    (LoopRaw),
      .LightState (LightState),
      .ClearFault (ClearFault),
      .CarDetected(CarDetected),
      .CarCount   (CarCount),
      .Fault      (Fault)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // One clean vehicle: 6 edges high, then 6 edges low; ends back in IDLE.
   task automatic car();
      LoopRaw = 1'b1;
      tick(6);
      LoopRaw = 1'b0;
      tick(6);
   endtask

   initial begin
      tests      = 0;
      failures   = 0;
      reset      = 1'b0;
      LoopRaw    = 1'b0;
      LightState = 2'd0;
      ClearFault = 1'b0;

      // Reset values
      #2;
      check("rst_cd", CarDetected, 0);
      check("rst_cnt", CarCount, 0);
      check("rst_fault", Fault, 0);
      #10 reset = 1'b1;
      tick(2);

      // Glitch rejection: 3 high edges never qualify
      LoopRaw = 1'b1;
      tick(3);
      LoopRaw = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick(1);
         check("glitch_cd", CarDetected, 0);
      end
      check("glitch_cnt", CarCount, 0);

      // Arrival and service: CarDetected rises exactly at k+5
      LoopRaw = 1'b1;
      tick(5);
      check("arr_cd_k4", CarDetected, 0);
      check("arr_cnt_k4", CarCount, 0);
      tick(1);
      check("arr_cd_k5", CarDetected, 1);
      check("arr_cnt_k5", CarCount, 1);
      tick(2);
      LoopRaw = 1'b0;
      tick(10);
      check("held_cd", CarDetected, 1);
      LightState = 2'd1;
      tick(1);
      check("green_cd", CarDetected, 0);
      LightState = 2'd0;
      tick(2);

      // Bounce during PRESENT: no recount
      LoopRaw = 1'b1;
      tick(6);
      check("bnc_cnt0", CarCount, 2);
      LoopRaw = 1'b0;
      tick(2);
      LoopRaw = 1'b1;
      tick(4);
      check("bnc_cd", CarDetected, 1);
      check("bnc_cnt1", CarCount, 2);
      LoopRaw = 1'b0;
      tick(8);
      check("bnc_cnt2", CarCount, 2);
      check("bnc_fault", Fault, 0);
      LightState = 2'd1;
      tick(1);
      check("bnc_green_cd", CarDetected, 0);
      LightState = 2'd0;

      // Saturation: 300 clean arrivals
      for (int i = 0; i < 300; i++) begin
         car();
         if (i == 251) check("sat_254", CarCount, 254);
      end
      check("sat_255", CarCount, 255);
      LightState = 2'd1;
      tick(1);
      LightState = 2'd0;
      check("sat_green_cd", CarDetected, 0);

      // Stuck sensor: Fault 16 edges after PRESENT entry
      LoopRaw = 1'b1;
      tick(6);
      check("stk_cd", CarDetected, 1);
      check("stk_fault0", Fault, 0);
      tick(15);
      check("stk_fault15", Fault, 0);
      tick(1);
      check("stk_fault16", Fault, 1);
      check("stk_cnt", CarCount, 255);
      LightState = 2'd1;
      LoopRaw    = 1'b0;
      tick(10);
      check("stk_forced_cd", CarDetected, 1);
      check("stk_fault_hold", Fault, 1);
      ClearFault = 1'b1;
      tick(1);
      ClearFault = 1'b0;
      check("clr_fault", Fault, 0);
      check("clr_cd", CarDetected, 0);
      LightState = 2'd0;
      tick(2);

      // Arrival coinciding with GREEN: set wins; invalid light never clears
      LoopRaw = 1'b1;
      tick(5);
      LightState = 2'd1;
      tick(1);
      check("sim_cd", CarDetected, 1);
      LightState = 2'd0;
      LoopRaw    = 1'b0;
      tick(8);
      check("sim_held_cd", CarDetected, 1);
      LightState = 2'd3;
      tick(3);
      check("inv_light_cd", CarDetected, 1);
      LightState = 2'd1;
      tick(1);
      check("sim_green_cd", CarDetected, 0);
      LightState = 2'd0;
      tick(2);

      // Reset mid-PRESENT with CarCount=3, then re-qualify
      reset = 1'b0;
      #1;
      reset = 1'b1;
      tick(1);
      car();
      car();
      LoopRaw = 1'b1;
      tick(6);
      check("pre_rst_cnt", CarCount, 3);
      check("pre_rst_cd", CarDetected, 1);
      #2 reset = 1'b0;
      #1;
      check("mid_rst_cd", CarDetected, 0);
      check("mid_rst_cnt", CarCount, 0);
      check("mid_rst_fault", Fault, 0);
      #1 reset = 1'b1;
      tick(5);
      check("rq_cd_k4", CarDetected, 0);
      check("rq_cnt_k4", CarCount, 0);
      tick(1);
      check("rq_cd_k5", CarDetected, 1);
      check("rq_cnt_k5", CarCount, 1);
      LoopRaw = 1'b0;
      tick(2);

      $display("[TB] %0d tests run, %0d failed", tests, failures);
      $finish;
   end

endmodule
